iodelay_tap_seq: RTL

- Upstream command sequencer for the per-channel IODELAY pulse stage.
- Turns a register-level request into a timed train of command levels: optional calibrate, reset, then N tap increments. The downstream stage synchronises these levels, edge-detects them and emits single-cycle del_cal, del_rst and del_ce.
- Each level is therefore held high for HOLD cycles and then low for GAP cycles, so every edge survives the downstream 2-FF sampling.
- Tracks the resulting tap position for readback over the slow-control bus.

---
 rtl/iodelay_pkg.sv | 34 +++
 rtl/iodelay_tap_seq_phase_timer.sv | 27 ++
 rtl/iodelay_tap_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/iodelay_pkg.sv
// Shared definitions for the IODELAY tap sequencer: state encoding,
// default phase lengths and the phase-timer width helper.
package iodelay_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CAL_HI = 3'd1;
  localparam logic [2:0] ST_CAL_LO = 3'd2;
  localparam logic [2:0] ST_RST_HI = 3'd3;
  localparam logic [2:0] ST_RST_LO = 3'd4;
  localparam logic [2:0] ST_INC_HI = 3'd5;
  localparam logic [2:0] ST_INC_LO = 3'd6;
  localparam logic [2:0] ST_FIN    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_CAL_HI = ST_CAL_HI,
    S_CAL_LO = ST_CAL_LO,
    S_RST_HI = ST_RST_HI,
    S_RST_LO = ST_RST_LO,
    S_INC_HI = ST_INC_HI,
    S_INC_LO = ST_INC_LO,
    S_FIN    = ST_FIN
  } state_t;

  localparam int DEF_HOLD     = 4;
  localparam int DEF_GAP      = 4;
  localparam int DEF_CAL_WAIT = 64;

  // Bits needed to hold a reload value of (count-1) for a phase of `count` cycles.
  function automatic int timer_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/iodelay_tap_seq_phase_timer.sv
// Loadable down-counter that times one command phase; zero marks the
// last cycle of the phase and the counter parks at zero afterwards.
module phase_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/iodelay_tap_seq.sv
// Command sequencer for the IODELAY pulse stage: optional calibrate, reset,
// then N tap increments as held levels with gaps; tracks the tap position.
module iodelay_tap_seq
  import iodelay_pkg::*;
#(
  parameter int TAP_W    = 5,
  parameter int MAX_TAP  = 31,
  parameter int HOLD     = DEF_HOLD,
  parameter int GAP      = DEF_GAP,
  parameter int CAL_WAIT = DEF_CAL_WAIT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [TAP_W-1:0] tap_req,
  input  logic             cal_en,
  input  logic             step,
  output logic             cmd_cal,
  output logic             cmd_rst,
  output logic             cmd_inc,
  output logic             busy,
  output logic             done,
  output logic [TAP_W-1:0] cur_tap
);

  localparam int LONGEST = (HOLD > GAP + CAL_WAIT) ? HOLD : GAP + CAL_WAIT;
  localparam int TMR_W   = timer_width(LONGEST);

  localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD - 1);
  localparam logic [TMR_W-1:0] GAP_LD    = TMR_W'(GAP - 1);
  localparam logic [TMR_W-1:0] CALGAP_LD = TMR_W'(GAP + CAL_WAIT - 1);
  localparam logic [TAP_W-1:0] MAX_V     = TAP_W'(MAX_TAP);

  // Command bit gi is high while the FSM sits in the matching *_HI state.
  localparam logic [2:0][2:0] CMD_HI_ST = {ST_INC_HI, ST_RST_HI, ST_CAL_HI};

  state_t           state_reg, state_next;
  logic [TAP_W-1:0] n_reg, n_next;
  logic [TAP_W-1:0] cur_tap_reg, cur_tap_next;
  logic [2:0]       cmd_reg;
  logic             busy_reg, done_reg;
  logic             tmr_load, tmr_zero;
  logic [TMR_W-1:0] tmr_val;

  phase_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_next   = state_reg;
    n_next       = n_reg;
    cur_tap_next = cur_tap_reg;
    tmr_load     = 1'b0;
    tmr_val      = HOLD_LD;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          n_next     = (tap_req > MAX_V) ? MAX_V : tap_req;
          tmr_load   = 1'b1;
          state_next = cal_en ? S_CAL_HI : S_RST_HI;
        end else if (step && (cur_tap_reg < MAX_V)) begin
          n_next     = TAP_W'(1);
          tmr_load   = 1'b1;
          state_next = S_INC_HI;
        end
      end
      S_CAL_HI: if (tmr_zero) begin
        tmr_load   = 1'b1;
        tmr_val    = CALGAP_LD;
        state_next = S_CAL_LO;
      end
      S_CAL_LO: if (tmr_zero) begin
        tmr_load   = 1'b1;
        state_next = S_RST_HI;
      end
      S_RST_HI: if (tmr_zero) begin
        tmr_load   = 1'b1;
        tmr_val    = GAP_LD;
        state_next = S_RST_LO;
      end
      S_RST_LO: if (tmr_zero) begin
        cur_tap_next = '0;
        if (n_reg != '0) begin
          tmr_load   = 1'b1;
          state_next = S_INC_HI;
        end else begin
          state_next = S_FIN;
        end
      end
      S_INC_HI: if (tmr_zero) begin
        tmr_load   = 1'b1;
        tmr_val    = GAP_LD;
        state_next = S_INC_LO;
      end
      S_INC_LO: if (tmr_zero) begin
        // Saturating guard: the clamp on n already keeps us at or below MAX_TAP.
        if (cur_tap_reg != MAX_V) cur_tap_next = cur_tap_reg + TAP_W'(1);
        n_next = n_reg - TAP_W'(1);
        if (n_reg > TAP_W'(1)) begin
          tmr_load   = 1'b1;
          state_next = S_INC_HI;
        end else begin
          state_next = S_FIN;
        end
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      n_reg       <= '0;
      cur_tap_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      n_reg       <= n_next;
      cur_tap_reg <= cur_tap_next;
      busy_reg    <= (state_next != S_IDLE) && (state_next != S_FIN);
      done_reg    <= (state_next == S_FIN);
    end
  end

  // Levels are decoded from the next state so they line up with the state register.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cmd
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cmd_reg[gi] <= 1'b0;
        else          cmd_reg[gi] <= (state_next == state_t'(CMD_HI_ST[gi]));
      end
    end
  endgenerate

  assign cmd_cal = cmd_reg[0];
  assign cmd_rst = cmd_reg[1];
  assign cmd_inc = cmd_reg[2];
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign cur_tap = cur_tap_reg;

endmodule
